// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control block: FSM state encodings
// and default prescaler sizing.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } sw_state_t;

  localparam int TICK_DIV_DEF = 100;
  localparam int CNT_W_DEF    = 7;

  function automatic logic is_counting(input sw_state_t s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_tick_gen.sv
// Prescaler for the stopwatch: counts enabled cycles modulo TICK_DIV and flags
// the cycle whose edge wraps the count (tick is combinational from the count).
module stopwatch_ctrl_tick_gen #(
  parameter int TICK_DIV = 100,
  parameter int CNT_W    = 7
) (
  input  logic clk_out,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign o_tick = i_en && w_wrap;

  // Disabled cycles hold the count, so a paused run resumes mid-period.
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: turns button pulses into run/pause/lap/clear actions
// and issues registered increment pulses to the BCD digit chain.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic       clk_out,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       lap_reset,
  input  logic       max_reached,
  output logic       inc,
  output logic       clr_cnt,
  output logic       freeze,
  output logic       running,
  output logic       done,
  output logic [1:0] state
);

  sw_state_t r_state;
  sw_state_t w_state_nxt;
  logic      r_inc,     w_inc_nxt;
  logic      r_clr,     w_clr_nxt;
  logic      r_freeze,  w_freeze_nxt;
  logic      r_running, w_running_nxt;
  logic      r_done,    w_done_nxt;
  logic      w_tick;
  logic      w_cnt_en;
  logic      w_cnt_clr;
  logic      w_sat;

  // Prescaler parks at zero in IDLE so every fresh run starts a full period.
  assign w_cnt_en  = is_counting(r_state);
  assign w_cnt_clr = (r_state == ST_IDLE);

  stopwatch_ctrl_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick_gen (
    .clk_out (clk_out),
    .rst     (rst),
    .i_en    (w_cnt_en),
    .i_clr   (w_cnt_clr),
    .o_tick  (w_tick)
  );

  assign w_sat = w_tick && max_reached;

  always_comb begin
    w_state_nxt  = r_state;
    w_inc_nxt    = 1'b0;
    w_clr_nxt    = 1'b0;
    w_freeze_nxt = r_freeze;
    w_done_nxt   = r_done;
    case (r_state)
      ST_IDLE: begin
        if (start_stop) begin
          w_state_nxt = ST_RUN;
          w_done_nxt  = 1'b0;
        end else if (lap_reset) begin
          w_clr_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_sat) begin
          w_state_nxt  = ST_PAUSE;
          w_done_nxt   = 1'b1;
          w_freeze_nxt = 1'b0;
        end else begin
          w_inc_nxt = w_tick;
          if (start_stop) begin
            w_state_nxt = ST_PAUSE;
          end else if (lap_reset) begin
            w_state_nxt  = ST_LAP;
            w_freeze_nxt = 1'b1;
          end
        end
      end
      ST_LAP: begin
        if (w_sat) begin
          w_state_nxt  = ST_PAUSE;
          w_done_nxt   = 1'b1;
          w_freeze_nxt = 1'b0;
        end else begin
          w_inc_nxt = w_tick;
          if (start_stop) begin
            w_state_nxt  = ST_PAUSE;
            w_freeze_nxt = 1'b0;
          end else if (lap_reset) begin
            w_state_nxt  = ST_RUN;
            w_freeze_nxt = 1'b0;
          end
        end
      end
      ST_PAUSE: begin
        if (start_stop) begin
          w_state_nxt = ST_RUN;
        end else if (lap_reset) begin
          w_state_nxt = ST_IDLE;
          w_clr_nxt   = 1'b1;
          w_done_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_running_nxt = is_counting(w_state_nxt);
  end

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_inc     <= 1'b0;
      r_clr     <= 1'b0;
      r_freeze  <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_inc     <= w_inc_nxt;
      r_clr     <= w_clr_nxt;
      r_freeze  <= w_freeze_nxt;
      r_running <= w_running_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign inc     = r_inc;
  assign clr_cnt = r_clr;
  assign freeze  = r_freeze;
  assign running = r_running;
  assign done    = r_done;
  assign state   = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=4: scenario tasks push expected inc
// edges to a queue; a per-cycle monitor pops and compares them.
module tb_stopwatch_ctrl;

  logic       clk_out;
  logic       rst;
  logic       start_stop;
  logic       lap_reset;
  logic       max_reached;
  logic       inc;
  logic       clr_cnt;
  logic       freeze;
  logic       running;
  logic       done;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;
  bit mon_en = 1'b0;
  int inc_q[$];

  stopwatch_ctrl #(
    .TICK_DIV (4),
    .CNT_W    (3)
  ) dut (
    .clk_out     (clk_out),
    .rst         (rst),
    .start_stop  (start_stop),
    .lap_reset   (lap_reset),
    .max_reached (max_reached),
    .inc         (inc),
    .clr_cnt     (clr_cnt),
    .freeze      (freeze),
    .running     (running),
    .done        (done),
    .state       (state)
  );

  initial clk_out = 1'b0;
  always #5 clk_out = ~clk_out;

  always @(posedge clk_out) edge_no <= edge_no + 1;

  // Scoreboard: every inc must land on the edge at the head of the queue.
  always @(posedge clk_out) begin
    #1;
    if (mon_en && !rst) begin
      if (inc_q.size() > 0 && inc_q[0] < edge_no) begin
        checks++; errors++;
        $display("FAIL inc_missing edge %0d: inc never seen, required at edge %0d", edge_no, inc_q[0]);
        void'(inc_q.pop_front());
      end
      if (inc === 1'b1) begin
        checks++;
        if (inc_q.size() == 0 || inc_q[0] != edge_no) begin
          errors++;
          $display("FAIL inc_unexpected edge %0d: inc=1, required inc=0", edge_no);
        end else begin
          void'(inc_q.pop_front());
        end
      end else if (inc_q.size() > 0 && inc_q[0] == edge_no) begin
        checks++; errors++;
        $display("FAIL inc_missing edge %0d: inc=%b, required inc=1", edge_no, inc);
        void'(inc_q.pop_front());
      end
      if (inc === 1'b1 && clr_cnt === 1'b1) begin
        checks++; errors++;
        $display("FAIL inc_clr_overlap edge %0d: inc=1 clr_cnt=1, required not both", edge_no);
      end
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) begin
      @(posedge clk_out);
      #1;
    end
  endtask

  task automatic pulse(input logic ss, input logic lr, output int e);
    start_stop = ss;
    lap_reset  = lr;
    @(posedge clk_out);
    #1;
    start_stop = 1'b0;
    lap_reset  = 1'b0;
    e = edge_no;
  endtask

  task automatic test_reset();
    int e;
    rst = 1'b1;
    wait_edges(3);
    checks++;
    if ({state, inc, clr_cnt, freeze, running, done} !== 7'b0) begin
      errors++;
      $display("FAIL reset_held: outputs=%b, required 0000000", {state, inc, clr_cnt, freeze, running, done});
    end
    rst = 1'b0;
    wait_edges(1);
    checks++;
    if ({state, inc, clr_cnt, freeze, running, done} !== 7'b0) begin
      errors++;
      $display("FAIL reset_release: outputs=%b, required 0000000", {state, inc, clr_cnt, freeze, running, done});
    end
    pulse(1'b1, 1'b0, e);
    checks++;
    if (state !== 2'd1 || running !== 1'b1) begin
      errors++;
      $display("FAIL reset_start: state=%0d running=%b, required state=1 running=1", state, running);
    end
    wait_edges(2);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (state !== 2'd0 || inc !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: state=%0d inc=%b running=%b, required 0 0 0", state, inc, running);
    end
    @(posedge clk_out);
    #1;
    rst = 1'b0;
    wait_edges(1);
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL reset_after: state=%0d, required 0", state);
    end
  endtask

  task automatic test_run_timing();
    int e, x;
    pulse(1'b1, 1'b0, e);
    inc_q.push_back(e + 4);
    inc_q.push_back(e + 8);
    inc_q.push_back(e + 12);
    checks++;
    if (state !== 2'd1 || running !== 1'b1) begin
      errors++;
      $display("FAIL run_enter: state=%0d running=%b, required state=1 running=1", state, running);
    end
    wait_edges(13);
    pulse(1'b1, 1'b0, x);
    checks++;
    if (state !== 2'd2 || running !== 1'b0) begin
      errors++;
      $display("FAIL run_pause: state=%0d running=%b, required state=2 running=0", state, running);
    end
    pulse(1'b0, 1'b1, x);
  endtask

  task automatic test_pause_resume();
    int e, r, x;
    pulse(1'b1, 1'b0, e);
    inc_q.push_back(e + 4);
    wait_edges(5);
    pulse(1'b1, 1'b0, x);
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL pause_enter: state=%0d, required 2", state);
    end
    wait_edges(10);
    pulse(1'b1, 1'b0, r);
    inc_q.push_back(r + 2);
    inc_q.push_back(r + 6);
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL pause_resume: state=%0d, required 1", state);
    end
    wait_edges(7);
    pulse(1'b1, 1'b0, x);
    pulse(1'b0, 1'b1, x);
  endtask

  task automatic test_lap();
    int e, x;
    pulse(1'b1, 1'b0, e);
    inc_q.push_back(e + 4);
    inc_q.push_back(e + 8);
    inc_q.push_back(e + 12);
    wait_edges(2);
    pulse(1'b0, 1'b1, x);
    checks++;
    if (state !== 2'd3 || freeze !== 1'b1 || running !== 1'b1) begin
      errors++;
      $display("FAIL lap_enter: state=%0d freeze=%b running=%b, required 3 1 1", state, freeze, running);
    end
    wait_edges(6);
    checks++;
    if (state !== 2'd3 || freeze !== 1'b1) begin
      errors++;
      $display("FAIL lap_hold: state=%0d freeze=%b, required 3 1", state, freeze);
    end
    pulse(1'b0, 1'b1, x);
    checks++;
    if (state !== 2'd1 || freeze !== 1'b0) begin
      errors++;
      $display("FAIL lap_exit: state=%0d freeze=%b, required 1 0", state, freeze);
    end
    wait_edges(1);
    pulse(1'b1, 1'b0, x);
    checks++;
    if (state !== 2'd2 || inc !== 1'b1) begin
      errors++;
      $display("FAIL stop_on_tick: state=%0d inc=%b, required 2 1", state, inc);
    end
    pulse(1'b0, 1'b1, x);
  endtask

  task automatic test_clear();
    int e, x;
    pulse(1'b1, 1'b0, e);
    pulse(1'b1, 1'b0, x);
    pulse(1'b0, 1'b1, x);
    checks++;
    if (state !== 2'd0 || clr_cnt !== 1'b1) begin
      errors++;
      $display("FAIL clear_from_pause: state=%0d clr_cnt=%b, required 0 1", state, clr_cnt);
    end
    wait_edges(1);
    checks++;
    if (clr_cnt !== 1'b0) begin
      errors++;
      $display("FAIL clear_one_cycle: clr_cnt=%b, required 0", clr_cnt);
    end
    pulse(1'b0, 1'b1, x);
    checks++;
    if (state !== 2'd0 || clr_cnt !== 1'b1) begin
      errors++;
      $display("FAIL clear_in_idle: state=%0d clr_cnt=%b, required 0 1", state, clr_cnt);
    end
    pulse(1'b1, 1'b1, x);
    checks++;
    if (state !== 2'd1 || clr_cnt !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("FAIL both_in_idle: state=%0d clr_cnt=%b running=%b, required 1 0 1", state, clr_cnt, running);
    end
    pulse(1'b1, 1'b1, x);
    checks++;
    if (state !== 2'd2 || freeze !== 1'b0) begin
      errors++;
      $display("FAIL both_in_run: state=%0d freeze=%b, required 2 0", state, freeze);
    end
    pulse(1'b0, 1'b1, x);
  endtask

  task automatic test_saturation();
    int e, x;
    pulse(1'b1, 1'b0, e);
    inc_q.push_back(e + 4);
    wait_edges(5);
    max_reached = 1'b1;
    wait_edges(3);
    checks++;
    if (state !== 2'd2 || done !== 1'b1 || inc !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL sat_run: state=%0d done=%b inc=%b running=%b, required 2 1 0 0", state, done, inc, running);
    end
    wait_edges(5);
    checks++;
    if (state !== 2'd2 || done !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold: state=%0d done=%b, required 2 1", state, done);
    end
    pulse(1'b0, 1'b1, x);
    checks++;
    if (state !== 2'd0 || done !== 1'b0 || clr_cnt !== 1'b1) begin
      errors++;
      $display("FAIL sat_clear: state=%0d done=%b clr_cnt=%b, required 0 0 1", state, done, clr_cnt);
    end
    max_reached = 1'b0;
    pulse(1'b1, 1'b0, e);
    inc_q.push_back(e + 4);
    pulse(1'b0, 1'b1, x);
    wait_edges(4);
    max_reached = 1'b1;
    wait_edges(3);
    checks++;
    if (state !== 2'd2 || freeze !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL sat_lap: state=%0d freeze=%b done=%b, required 2 0 1", state, freeze, done);
    end
    pulse(1'b0, 1'b1, x);
    max_reached = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    start_stop  = 1'b0;
    lap_reset   = 1'b0;
    max_reached = 1'b0;
    @(posedge clk_out);
    #1;
    mon_en = 1'b1;
    test_reset();
    test_run_timing();
    test_pause_resume();
    test_lap();
    test_clear();
    test_saturation();
    wait_edges(3);
    checks++;
    if (inc_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d inc pulses outstanding, required 0", inc_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
